// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-through, no-write-allocate data cache
// controller sitting between a core and a line-oriented main memory.
//
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   cpu_req_i/we_i     core request valid and store (1) / load (0) select
//   cpu_addr_i         byte address; bits [1:0] are ignored
//   cpu_wdata_i        store data
//   cpu_rdata_o        load data (valid when a load is not stalled)
//   cpu_stall_o        core holds its request while this is high
//   mem_req_o/we_o     memory request valid; 1 = word write, 0 = line read
//   mem_addr_o         word address (write) or line-aligned address (read)
//   mem_wdata_o        memory write data
//   mem_rdata_i        fill line, word k in bits [32k+31:32k]
//   mem_ready_i        one-cycle completion pulse of the outstanding request
//   dbg_state_o        current FSM state (0 IDLE, 1 RD_MISS, 2 WR_MEM)
//
// Handshake: the core raises cpu_req_i and keeps request fields stable while
// cpu_stall_o=1; a request completes in the first cycle it sees
// cpu_stall_o=0. Memory requests stay asserted with stable fields until the
// single-cycle mem_ready_i; only one memory request is ever outstanding.
module dcache_ctrl #(
  parameter int LINES     = 32,
  parameter int MEM_WORDS = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic [31:0]               cpu_addr_i,
  input  logic [31:0]               cpu_wdata_i,
  output logic [31:0]               cpu_rdata_o,
  output logic                      cpu_stall_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [32*MEM_WORDS-1:0]   mem_rdata_i,
  input  logic                      mem_ready_i,
  output logic [1:0]                dbg_state_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_MISS = 2'd1, WR_MEM = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [TAG_W-1:0]         tag_d  [LINES];
  logic [31:0]              data_q [LINES][MEM_WORDS];
  logic [31:0]              data_d [LINES][MEM_WORDS];
  logic [29:0]              addr_q, addr_d;   // latched word address (addr[31:2])
  logic [31:0]              wdata_q, wdata_d;
  logic                     we_q, we_d;
  // High for the single IDLE cycle in which the core retires a finished
  // store; the still-present store request must not be taken again.
  logic                     wr_done_q, wr_done_d;

  logic [1:0]               cpu_off;
  logic [IDX_W-1:0]         cpu_idx;
  logic [TAG_W-1:0]         cpu_tag;
  logic [IDX_W-1:0]         lat_idx;
  logic [TAG_W-1:0]         lat_tag;
  logic                     cpu_hit;
  logic                     accept;
  logic                     unused_addr_bits;

  assign cpu_off          = cpu_addr_i[3:2];
  assign cpu_idx          = cpu_addr_i[4 +: IDX_W];
  assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
  assign lat_idx          = addr_q[2 +: IDX_W];
  assign lat_tag          = addr_q[29 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign accept  = (state_q == IDLE) && cpu_req_i && !wr_done_q;
  assign dbg_state_o = state_q;

  // State register plus storage. Reset only clears valid bits; tags and
  // data are left alone, which also keeps a coinciding fill from landing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cpu_we_i)      state_d = WR_MEM;
          else if (!cpu_hit) state_d = RD_MISS;
        end
      end
      RD_MISS: if (mem_ready_i) state_d = IDLE;
      WR_MEM:  if (mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage and request-latch updates.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    wr_done_d = (state_q == WR_MEM) && mem_ready_i;

    if (state_q == IDLE && state_d != IDLE) begin
      addr_d  = cpu_addr_i[31:2];
      wdata_d = cpu_wdata_i;
      we_d    = cpu_we_i;
    end

    // Store hit: update the cached word as the write goes out to memory.
    if (accept && cpu_we_i && cpu_hit)
      data_d[cpu_idx][cpu_off] = cpu_wdata_i;

    if (state_q == RD_MISS && mem_ready_i) begin
      valid_d[lat_idx] = 1'b1;
      tag_d[lat_idx]   = lat_tag;
      for (int w = 0; w < MEM_WORDS; w++)
        data_d[lat_idx][w] = mem_rdata_i[32*w +: 32];
    end
  end

  // Output logic.
  always_comb begin
    cpu_rdata_o = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !cpu_we_i && cpu_hit)
          cpu_rdata_o = data_q[cpu_idx][cpu_off];
        if (accept && (cpu_we_i || !cpu_hit))
          cpu_stall_o = 1'b1;
      end
      RD_MISS: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[29:2], 4'b0000};
      end
      WR_MEM: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q, 2'b00};
        mem_wdata_o = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl. The reference is a word-addressed memory image plus
// a table of which line address is resident in each cache slot; because the
// cache is write-through, any hit must return the current memory word.
module tb_dcache_ctrl;

  localparam int LINES = 32;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ready_i;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [logic [31:0]];
  int          resident [LINES];

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(LINES), .MEM_WORDS(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .dbg_state_o(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [127:0] fill_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++)
      l[32*w +: 32] = get_word({a[31:4], 4'h0} + 32'(4 * w));
    return l;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One complete core access; lat is the number of cycles the memory
  // request stays up before mem_ready_i.
  task automatic access(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat);
    logic [31:0] a;
    int line;
    bit hit;
    a    = {addr[31:2], 2'b00};
    line = int'(a >> 4);
    hit  = (resident[line % LINES] == line);
    tick();
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    @(negedge clk);
    if (!we && hit) begin
      chk("hit_stall", cpu_stall_o, 0);
      chk("hit_rdata", cpu_rdata_o, get_word(a));
      chk("hit_no_mem", mem_req_o, 0);
    end else begin
      chk("req_stall", cpu_stall_o, 1);
      chk("req_no_mem_yet", mem_req_o, 0);
      for (int k = 1; k <= lat; k++) begin
        tick();
        if (we) begin
          cpu_addr_i  = $urandom;
          cpu_wdata_i = $urandom;
        end
        if (k == lat) begin
          mem_ready_i = 1'b1;
          if (!we) mem_rdata_i = fill_line(a);
        end
        @(negedge clk);
        chk("busy_stall", cpu_stall_o, 1);
        chk("busy_mem_req", mem_req_o, 1);
        chk("busy_mem_we", mem_we_o, {31'b0, we});
        chk("busy_mem_addr", mem_addr_o, we ? a : {a[31:4], 4'h0});
        if (we) chk("busy_mem_wdata", mem_wdata_o, wd);
      end
      tick();
      mem_ready_i = 1'b0;
      mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      cpu_addr_i  = addr;
      cpu_wdata_i = wd;
      if (we) mem_m[a] = wd;
      else    resident[line % LINES] = line;
      @(negedge clk);
      chk("done_stall", cpu_stall_o, 0);
      chk("done_no_mem", mem_req_o, 0);
      if (!we) chk("fill_rdata", cpu_rdata_o, get_word(a));
    end
    tick();
    cpu_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < LINES; i++) resident[i] = -1;
    reset_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = '0; cpu_wdata_i = '0; mem_rdata_i = '0; mem_ready_i = 1'b0;
    repeat (2) tick();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rdata", cpu_rdata_o, 0);

    // Line at 0x60 holds {4,3,2,1}; the 0x64 load returns 2 on cycle 5.
    mem_m[32'h60] = 32'h1; mem_m[32'h64] = 32'h2;
    mem_m[32'h68] = 32'h3; mem_m[32'h6C] = 32'h4;
    access(1'b0, 32'h64, 32'h0, 3);
    access(1'b0, 32'h64, 32'h0, 1);
    chk("dir_hit_value", get_word(32'h64), 32'h2);

    access(1'b1, 32'h64, 32'hFFFF_F8AE, 2);
    access(1'b0, 32'h64, 32'h0, 1);

    // Store to a conflicting tag must not allocate or disturb 0x64.
    access(1'b1, 32'h264, 32'h1234_5678, 3);
    access(1'b0, 32'h64, 32'h0, 1);

    // Stray mem_ready_i while idle.
    tick();
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("stray_stall", cpu_stall_o, 0);
    chk("stray_mem_req", mem_req_o, 0);
    tick();
    mem_ready_i = 1'b0;
    access(1'b0, 32'h64, 32'h0, 1);

    // Reset in RD_MISS together with mem_ready_i.
    tick();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h2000;
    @(negedge clk);
    chk("rstmiss_stall", cpu_stall_o, 1);
    tick();
    @(negedge clk);
    chk("rstmiss_mem_req", mem_req_o, 1);
    tick();
    reset_i = 1'b1; mem_ready_i = 1'b1; mem_rdata_i = fill_line(32'h2000);
    tick();
    reset_i = 1'b0; mem_ready_i = 1'b0; cpu_req_i = 1'b0;
    for (int i = 0; i < LINES; i++) resident[i] = -1;
    @(negedge clk);
    chk("rstmiss_idle_stall", cpu_stall_o, 0);
    chk("rstmiss_idle_req", mem_req_o, 0);
    chk("rstmiss_idle_addr", mem_addr_o, 0);
    access(1'b0, 32'h64, 32'h0, 2);
    access(1'b0, 32'h2000, 32'h0, 1);

    // Random mix over a few indices and tags to force hits and conflicts.
    for (int n = 0; n < 80; n++) begin
      ra = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        tick();
        mem_ready_i = 1'b1;
        @(negedge clk);
        chk("rnd_stray_req", mem_req_o, 0);
        tick();
        mem_ready_i = 1'b0;
      end
      access(($urandom_range(0, 2) == 0), ra, $urandom, $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter LINES, default 32, giving the number of direct-mapped cache lines, a power of two.
REQ-002 The block SHALL have parameter MEM_WORDS, default 4, giving the 32-bit words per line and per memory fill beat, fixed at 4 for this revision.
REQ-003 clk_i  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 cpu_req_i  input  1  core data request valid, for a load or a store.
REQ-006 cpu_we_i  input  1  1 = store, 0 = load; qualified by cpu_req_i.
REQ-007 cpu_addr_i  input  32  byte address; bits [1:0] ignored (word access only).
REQ-008 cpu_wdata_i  input  32  store data.
REQ-009 cpu_rdata_o  output  32  load data, valid when cpu_req_i=1, cpu_we_i=0, cpu_stall_o=0.
REQ-010 cpu_stall_o  output  1  core SHALL hold its request stable while this is high.
REQ-011 mem_req_o  output  1  main-memory request valid.
REQ-012 mem_we_o  output  1  1 = single-word write, 0 = line read.
REQ-013 mem_addr_o  output  32  word address for a write; line-aligned (bits [3:0]=0) for a read.
REQ-014 mem_wdata_o  output  32  write data to memory.
REQ-015 mem_rdata_i  input  128  fill line; word k is in bits [32k+31:32k].
REQ-016 mem_ready_i  input  1  one-cycle completion pulse for the outstanding memory request.

Function
REQ-017 Address split SHALL be: offset = addr[3:2]; index = addr[3+log2(LINES):4]; tag = the remaining upper bits.
REQ-018 Per line, storage SHALL be one valid bit, one tag and MEM_WORDS data words.
REQ-019 A hit SHALL be defined as valid[index] and tag match.
REQ-020 FSM states SHALL be IDLE, RD_MISS and WR_MEM.
REQ-021 In IDLE, a load hit SHALL drive cpu_rdata_o combinationally in the same cycle with cpu_stall_o=0, for zero added latency.
REQ-022 In IDLE, a load miss SHALL set cpu_stall_o=1 combinationally and go to RD_MISS on the next edge.
REQ-023 In RD_MISS, mem_req_o=1, mem_we_o=0 and mem_addr_o={addr[31:4],4'b0} SHALL be held until mem_ready_i.
REQ-024 On mem_ready_i in RD_MISS, the block SHALL write the full line, tag and valid=1, then return to IDLE.
REQ-025 The stalled load SHALL then hit on the following cycle, giving a miss latency of memory latency + 2 cycles.
REQ-026 Stores SHALL be write-through with no write-allocate.
REQ-027 In IDLE, any store SHALL assert cpu_stall_o=1 combinationally.
REQ-028 On a store hit, the addressed cached word SHALL be updated at the same edge the FSM enters WR_MEM.
REQ-029 On a store miss, cache contents SHALL be left unchanged.
REQ-030 In WR_MEM, mem_req_o=1, mem_we_o=1, mem_addr_o={addr[31:2],2'b0} and mem_wdata_o=cpu_wdata_i (the value latched at entry) SHALL be held until mem_ready_i.
REQ-031 After mem_ready_i in WR_MEM, the FSM SHALL return to IDLE with cpu_stall_o=0 for exactly one cycle, so the core retires the store.
REQ-032 The block SHALL NOT re-accept that same store.
REQ-033 The request address, data and we SHALL be latched on leaving IDLE, so memory outputs stay stable even if core inputs glitch.
REQ-034 mem_ready_i in IDLE SHALL be ignored.
REQ-035 cpu_req_i=0 in IDLE SHALL keep cpu_stall_o=0, mem_req_o=0 and all state unchanged.
REQ-036 cpu_stall_o SHALL be 1 in every cycle spent in RD_MISS or WR_MEM.
REQ-037 Only one memory request SHALL be outstanding at any time.

Reset
REQ-038 When reset_i=1 at a clock edge, the block SHALL go to IDLE and clear all valid bits.
REQ-039 Reset SHALL leave tag and data storage unchanged.
REQ-040 During and after reset, cpu_stall_o, mem_req_o and mem_we_o SHALL be 0, and mem_addr_o, mem_wdata_o and cpu_rdata_o SHALL be 0 while in IDLE with no hit.
REQ-041 Reset during RD_MISS or WR_MEM SHALL abort the request.
REQ-042 A mem_ready_i coinciding with reset SHALL NOT fill any line.

Verification
REQ-043 After reset, load 0x0000_0064 -> stall=1, mem read of 0x0000_0060; mem_ready_i after 3 cycles with line {0x4,0x3,0x2,0x1} -> cpu_rdata_o=0x2 with stall=0 on the 5th cycle.
REQ-044 Repeat load 0x64 -> cpu_rdata_o=0x2 in the same cycle, no mem_req_o.
REQ-045 Store 0xFFFFF8AE to 0x64 (hit) -> mem write addr 0x64 data 0xFFFFF8AE; a subsequent load 0x64 hits with 0xFFFFF8AE.
REQ-046 Store to 0x0000_0264 (same index, different tag) -> mem write issued; a subsequent load 0x64 still hits with 0xFFFFF8AE (no allocate).
REQ-047 Assert reset_i during RD_MISS with mem_ready_i the same cycle -> IDLE, a following load 0x64 misses.
REQ-048 Idle cycles with a stray mem_ready_i pulse -> no state change, mem_req_o=0.
